// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding selects and load-use stall/bubble control for a 5-stage MIPS pipeline.
// Macro HAZ_FWD_EN builds the forwarding muxes; without it every RAW hazard is resolved by stalling.
module fwd_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 16,
  parameter bit RF_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } slot_t;

  localparam logic [1:0] SEL_RF    = 2'b11;
  localparam logic [1:0] SEL_EXMEM = 2'b10;
  localparam logic [1:0] SEL_MEMWB = 2'b01;

  slot_t            r_ex;
  slot_t            r_mem;
  slot_t            r_wb;
  logic [CNT_W-1:0] r_stall_cnt;

  slot_t            w_id_slot;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_hazard;
  logic             w_unused;

  // Register $0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic writes(input slot_t s, input logic [REG_AW-1:0] r);
    return s.vld && s.regwrite && (s.rd == r) && (r != '0);
  endfunction

  assign w_id_slot = '{vld: id_valid, rs: id_rs, rt: id_rt, rd: id_rd,
                       regwrite: id_regwrite, memread: id_memread};

  always_comb begin
    w_fwd_a  = SEL_RF;
    w_fwd_b  = SEL_RF;
    w_hazard = 1'b0;
`ifdef HAZ_FWD_EN
    if (r_ex.vld) begin
      if (writes(r_mem, r_ex.rs))
        w_fwd_a = SEL_EXMEM;
      else if (writes(r_wb, r_ex.rs))
        w_fwd_a = SEL_MEMWB;
      if (writes(r_mem, r_ex.rt))
        w_fwd_b = SEL_EXMEM;
      else if (writes(r_wb, r_ex.rt))
        w_fwd_b = SEL_MEMWB;
    end
    // Only a load in EX cannot be forwarded in time; one bubble moves it to MEM.
    w_hazard = id_valid && r_ex.memread &&
               (writes(r_ex, id_rs) || writes(r_ex, id_rt));
`else
    // No bypass paths: hold the consumer until every in-flight producer has written back.
    w_hazard = id_valid &&
               (writes(r_ex, id_rs)  || writes(r_ex, id_rt)  ||
                writes(r_mem, id_rs) || writes(r_mem, id_rt) ||
                (!RF_BYPASS && (writes(r_wb, id_rs) || writes(r_wb, id_rt))));
`endif
  end

  assign fwd_a_sel = w_fwd_a;
  assign fwd_b_sel = w_fwd_b;
  assign stall     = w_hazard && !flush;
  assign bubble    = w_hazard && !flush;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (bubble || flush)
        r_ex <= '0;
      else
        r_ex <= w_id_slot;
      if (stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign w_unused = ^{r_ex, r_mem, r_wb, RF_BYPASS};

endmodule
